// File: rtl/fpga_debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_debug_pkg
//  Purpose  : Shared types, ASCII constants and helpers for the exit-status
//             debug UART reporter (FSM state enums, frame layout, nibble to
//             uppercase hex conversion).
//  Revision : 1.0 - initial release
// ============================================================================
package fpga_debug_pkg;

    // Character sequencer states (top level)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XMIT = 2'd2,
        ST_DONE = 2'd3
    } rpt_state_t;

    // Byte serialiser states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int          FRAME_LEN         = 15;
    localparam logic [39:0] ASCII_EXIT_PREFIX = 40'h45_58_49_54_3A; // "EXIT:"
    localparam logic [7:0]  ASCII_CR          = 8'h0D;
    localparam logic [7:0]  ASCII_LF          = 8'h0A;

    // 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    // Character at position idx of "EXIT:" + 8 hex digits + CR LF
    function automatic logic [7:0] frame_char(input logic [3:0]  idx,
                                              input logic [31:0] value);
        logic [7:0] ch;
        logic [2:0] pos;
        logic [3:0] nib;
        ch  = ASCII_LF;
        // idx 5 selects the top nibble (pos 7), idx 12 the bottom (pos 0)
        pos = 3'(4'd12 - idx);
        nib = value[{pos, 2'b00} +: 4];
        case (idx)
            4'd0:    ch = ASCII_EXIT_PREFIX[39:32];
            4'd1:    ch = ASCII_EXIT_PREFIX[31:24];
            4'd2:    ch = ASCII_EXIT_PREFIX[23:16];
            4'd3:    ch = ASCII_EXIT_PREFIX[15:8];
            4'd4:    ch = ASCII_EXIT_PREFIX[7:0];
            4'd5, 4'd6, 4'd7, 4'd8,
            4'd9, 4'd10, 4'd11, 4'd12:
                     ch = nibble_to_ascii(nib);
            4'd13:   ch = ASCII_CR;
            default: ch = ASCII_LF;
        endcase
        return ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_byte
//  Purpose  : 8N1 byte serialiser with valid/ready handshake.
//  Ports    : clk_i, rst_ni (async, active-low)
//             i_valid/i_data  byte offered; accepted when o_ready is high
//             o_ready         serialiser idle
//             o_tx            registered TX line, idle high
//             o_last          high during the final cycle of the stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import fpga_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 130
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_last
);

    localparam int                 c_CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t          r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_tx, w_tx_nxt;
    logic               w_cnt_wrap;
    logic               w_last;

    assign w_cnt_wrap = (r_cnt == c_CNT_MAX);
    assign o_ready    = (r_state == TX_IDLE);
    assign o_tx       = r_tx;
    assign o_last     = w_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_data  <= w_data_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_data_nxt  = r_data;
        w_last      = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            TX_IDLE: begin
                if (i_valid) begin
                    w_data_nxt  = i_data;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = TX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = TX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin // TX_STOP
                if (w_cnt_wrap) begin
                    w_cnt_nxt   = '0;
                    w_last      = 1'b1;
                    w_state_nxt = TX_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
        // Line level is decoded from the next state so the pin is a flop
        // output and changes exactly on the bit boundary.
        case (w_state_nxt)
            TX_START: w_tx_nxt = 1'b0;
            TX_DATA:  w_tx_nxt = w_data_nxt[w_bit_nxt];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exit_status_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : exit_status_uart_reporter
//  Purpose  : Captures the SoC exit code on the rising edge of exit_valid_i,
//             drives sticky pass/fail LEDs and prints "EXIT:XXXXXXXX\r\n"
//             on an 8N1 TX-only debug UART.
//  Ports    : clk_i, rst_ni (async, active-low)
//             exit_valid_i / exit_value_i  SoC exit flag and code
//             tx_o                         UART TX, idle high
//             busy_o                       frame in progress
//             done_o                       one-cycle end-of-frame pulse
//             exit_ok_led_o/exit_fail_led_o sticky result LEDs
//  Revision : 1.0 - initial release
// ============================================================================
module exit_status_uart_reporter
    import fpga_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 130,
    parameter int EXIT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              exit_valid_i,
    input  logic [EXIT_W-1:0] exit_value_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              exit_ok_led_o,
    output logic              exit_fail_led_o
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("CLKS_PER_BIT must be >= 2");
        end
        if (EXIT_W != 32) begin : g_bad_exit_w
            $error("EXIT_W must be 32");
        end
    endgenerate

    localparam logic [3:0] c_LAST_IDX = 4'(FRAME_LEN - 1);

    rpt_state_t        r_state, w_state_nxt;
    logic [3:0]        r_idx, w_idx_nxt;
    logic              r_valid_q;
    logic [EXIT_W-1:0] r_capture;
    logic              r_ok_led, r_fail_led;
    logic              w_edge;
    logic              w_capture_en;
    logic              w_tx_valid;
    logic              w_tx_ready;
    logic              w_tx_last;
    logic [7:0]        w_char;

    // History resets to 0, so a level already high at reset release is an edge
    assign w_edge = exit_valid_i & ~r_valid_q;
    assign w_char = frame_char(r_idx, r_capture);

    assign busy_o          = (r_state == ST_LOAD) || (r_state == ST_XMIT);
    assign done_o          = (r_state == ST_DONE);
    assign exit_ok_led_o   = r_ok_led;
    assign exit_fail_led_o = r_fail_led;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_valid_q  <= 1'b0;
            r_capture  <= '0;
            r_ok_led   <= 1'b0;
            r_fail_led <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_valid_q <= exit_valid_i;
            if (w_capture_en) begin
                r_capture  <= exit_value_i;
                // Sticky: two differing captures light both LEDs
                r_ok_led   <= r_ok_led   | (exit_value_i == '0);
                r_fail_led <= r_fail_led | (exit_value_i != '0);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_capture_en = 1'b0;
        w_tx_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Edges outside IDLE are dropped, never queued
                if (w_edge) begin
                    w_capture_en = 1'b1;
                    w_idx_nxt    = '0;
                    w_state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_tx_valid = 1'b1;
                if (w_tx_ready) begin
                    w_state_nxt = ST_XMIT;
                end
            end
            ST_XMIT: begin
                if (w_tx_last) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            default: begin // ST_DONE
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (w_tx_valid),
        .i_data  (w_char),
        .o_ready (w_tx_ready),
        .o_tx    (tx_o),
        .o_last  (w_tx_last)
    );

endmodule
`default_nettype wire
